regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 33 +++
 rtl/regfile_writeback.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// Writeback bus for regfile_writeback: ALU result, load issue/response and
// register-file write port, with master (producer/consumer side) and slave (DUT) views.
interface regfile_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wen;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  wen, a3, wd, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output wen, a3, wd, busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win, load responses queue in a
// DEPTH-entry FIFO. Define REGFILE_WB_SCOREBOARD_EN to enable the pending-load busy flags.
module regfile_writeback #(
  parameter int unsigned DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_writeback_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic        wen_q;
  logic [4:0]  a3_q;
  logic [31:0] wd_q;

  logic        ld_ready;
  logic        push;
  logic        pop;
  logic        alu_wr;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ld_ready  = (count_q < CW'(DEPTH));
  assign alu_wr    = bus.alu_valid && (bus.alu_rd != '0);
  // Loads to x0 are accepted so the producer is not stalled, but never enqueued.
  assign push      = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
  assign pop       = !alu_wr && (count_q != '0);
  assign head_rd   = rd_mem[head_q];
  assign head_data = data_mem[head_q];

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= bus.ld_rd;
      data_mem[tail_q] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= 1'b0;
      a3_q  <= '0;
      wd_q  <= '0;
    end else if (alu_wr) begin
      wen_q <= 1'b1;
      a3_q  <= bus.alu_rd;
      wd_q  <= bus.alu_data;
    end else if (pop) begin
      wen_q <= 1'b1;
      a3_q  <= head_rd;
      wd_q  <= head_data;
    end else begin
      wen_q <= 1'b0;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.wen      = wen_q;
  assign bus.a3       = a3_q;
  assign bus.wd       = wd_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Clear first, then set, so a re-issue on the retiring edge keeps the flag.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_rd != '0)) busy_d[bus.ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{bus.ld_issue, bus.ld_issue_rd};
  assign bus.busy     = '0;
`endif

endmodule
